// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//   Instruction-memory responder for the fetch stage. Serves a 32-bit word
//   per fetch address combinationally and owns a byte-serial program loader
//   that fills the word array from a boot/debug byte channel. While a load
//   is in progress the fetch stage is held stalled and sees NOP_WORD.
//
//   Optional feature macro: IMEM_CHECKSUM_EN
//     Defined  : an 8-bit modular sum of the data bytes is kept during the
//                load; one trailing checksum byte must bring sum+byte to 0,
//                otherwise the sticky o_ld_err is raised.
//     Undefined: no checksum phase, o_ld_err tied low.
//
// Parameters
//   DEPTH_LOG2  log2 of the array depth in 32-bit words
//   NOP_WORD    word returned for out-of-range fetches and during a load
//
// Ports
//   clk                 system clock, all state on posedge
//   nrst                asynchronous active-low reset
//   i_IF_mem_ImemAddr   byte fetch address from the fetch stage
//   o_IF_mem_ImemDataR  instruction word (combinational)
//   o_IF_ctrl_Stall     fetch stage must hold its PC
//   i_ld_start          one-cycle pulse: begin a load (accepted only when idle)
//   i_ld_len            word count, sampled with an accepted start
//   i_ld_valid          i_ld_byte valid this cycle
//   i_ld_byte           load byte, little-endian within each word
//   o_ld_ready          loader accepts a byte this cycle
//   o_ld_busy           loader active
//   o_ld_err            sticky checksum error
// ---------------------------------------------------------------------------
module imem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] NOP_WORD   = 32'h0
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [31:0]           i_IF_mem_ImemAddr,
    output logic [31:0]           o_IF_mem_ImemDataR,
    output logic                  o_IF_ctrl_Stall,
    input  logic                  i_ld_start,
    input  logic [DEPTH_LOG2:0]   i_ld_len,
    input  logic                  i_ld_valid,
    input  logic [7:0]            i_ld_byte,
    output logic                  o_ld_ready,
    output logic                  o_ld_busy,
    output logic                  o_ld_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam logic [LW-1:0] LEN_MAX = LW'(DEPTH);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
`ifdef IMEM_CHECKSUM_EN
    localparam logic [1:0] ST_CSUM = 2'd2;
`endif

    // ---------------- state ----------------
    logic [1:0]    state_q,    state_d;
    logic [LW-1:0] len_q,      len_d;
    logic [PW-1:0] ptr_q,      ptr_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [31:0]   shift_q,    shift_d;
`ifdef IMEM_CHECKSUM_EN
    logic [7:0]    sum_q,      sum_d;
    logic          err_q,      err_d;
`endif

    logic          wr_en;
    logic [31:0]   wr_data;
    logic          xfer;
    logic          last_word;
    logic          loading;

    logic [31:0]   mem_q [DEPTH];

    // Loader is active in every state other than RUN; ready/stall/busy all
    // decode straight from the state register so there is no bubble.
    assign loading         = (state_q != ST_RUN);
    assign o_ld_ready      = loading;
    assign o_ld_busy       = loading;
    assign o_IF_ctrl_Stall = loading;

    assign xfer      = i_ld_valid && loading;
    assign last_word = ({1'b0, ptr_q} == (len_q - LW'(1)));

    // ---------------- read path ----------------
    logic [PW-1:0] rd_idx;
    logic          rd_in_range;
    logic          unused_addr_bits;

    assign rd_idx           = i_IF_mem_ImemAddr[DEPTH_LOG2+1:2];
    assign rd_in_range      = (i_IF_mem_ImemAddr[31:DEPTH_LOG2+2] == '0);
    assign unused_addr_bits = ^i_IF_mem_ImemAddr[1:0];

    assign o_IF_mem_ImemDataR = (!loading && rd_in_range) ? mem_q[rd_idx] : NOP_WORD;

    // ---------------- next-state / datapath ----------------
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        ptr_d      = ptr_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        wr_en      = 1'b0;
        wr_data    = {i_ld_byte, shift_q[23:0]};
`ifdef IMEM_CHECKSUM_EN
        sum_d      = sum_q;
        err_d      = err_q;
`endif

        case (state_q)
            ST_RUN: begin
                // Start wins over a coincident byte; the byte is dropped.
                if (i_ld_start) begin
                    len_d      = (i_ld_len > LEN_MAX) ? LEN_MAX : i_ld_len;
                    ptr_d      = '0;
                    byte_cnt_d = '0;
`ifdef IMEM_CHECKSUM_EN
                    sum_d      = '0;
                    err_d      = 1'b0;
`endif
                    if (i_ld_len != '0) begin
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                if (xfer) begin
                    shift_d[{byte_cnt_q, 3'b000} +: 8] = i_ld_byte;
`ifdef IMEM_CHECKSUM_EN
                    sum_d = sum_q + i_ld_byte;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        // Fourth byte completes the word; write it this edge.
                        wr_en      = 1'b1;
                        byte_cnt_d = '0;
                        if (last_word) begin
`ifdef IMEM_CHECKSUM_EN
                            state_d = ST_CSUM;
`else
                            state_d = ST_RUN;
`endif
                        end else begin
                            ptr_d = ptr_q + PW'(1);
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end

`ifdef IMEM_CHECKSUM_EN
            ST_CSUM: begin
                // Trailing byte is the two's complement of the data sum.
                if (xfer) begin
                    if (8'(sum_q + i_ld_byte) != 8'h00) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_RUN;
                end
            end
`endif

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_RUN;
            len_q      <= '0;
            ptr_q      <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
`ifdef IMEM_CHECKSUM_EN
            sum_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            ptr_q      <= ptr_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
`ifdef IMEM_CHECKSUM_EN
            sum_q      <= sum_d;
            err_q      <= err_d;
`endif
        end
    end

`ifdef IMEM_CHECKSUM_EN
    assign o_ld_err = err_q;
`else
    assign o_ld_err = 1'b0;
`endif

    // Word array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[ptr_q] <= wr_data;
        end
    end

endmodule
